// File: rtl/fft_io_sequencer_pkg.sv
// Shared definitions for the FFT I/O sequencer: sequencer states, address
// width helper, word width and the bank that holds the final-stage results.
package fft_io_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    // Ceiling log2; used for address widths of power-of-two transform lengths.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Word width of one real/imag component: integer plus fractional bits.
    function automatic int unsigned word_width(input int unsigned i, input int unsigned f);
        return i + f;
    endfunction

    // Stages alternate between the two banks, so the final stage lands in
    // RAM2 (1) when the last stage index log2(N)-1 is odd, else in RAM1 (0).
    function automatic logic result_bank(input int unsigned n);
        return ((log2(n) - 1) % 2) == 1;
    endfunction

endpackage

// File: rtl/fft_io_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings: input sample
// stream, RAM1 load port, transform controller handshake, result-bank read
// port and output sample stream. The sequencer is the master of this bundle.
interface fft_io_sequencer_if #(
    parameter int unsigned N = 8,
    parameter int unsigned I = 4,
    parameter int unsigned F = 4
);
    import fft_io_sequencer_pkg::*;

    localparam int unsigned AW = log2(N);
    localparam int unsigned W  = word_width(I, F);

    logic          i_in_valid;
    logic          o_in_ready;
    logic [W-1:0]  i_in_re;
    logic [W-1:0]  i_in_im;
    logic          o_load_sel;
    logic          o_load_wr_en;
    logic [AW-1:0] o_load_wr_addr;
    logic [W-1:0]  o_load_re;
    logic [W-1:0]  o_load_im;
    logic          o_transform;
    logic          i_done_transform;
    logic          o_res_rd_en;
    logic [AW-1:0] o_res_rd_addr;
    logic          o_res_bank;
    logic [W-1:0]  i_res_re;
    logic [W-1:0]  i_res_im;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [W-1:0]  o_out_re;
    logic [W-1:0]  o_out_im;
    logic          o_out_last;
    logic          o_busy;

    modport master (
        input  i_in_valid, i_in_re, i_in_im, i_done_transform,
               i_res_re, i_res_im, i_out_ready,
        output o_in_ready, o_load_sel, o_load_wr_en, o_load_wr_addr,
               o_load_re, o_load_im, o_transform, o_res_rd_en,
               o_res_rd_addr, o_res_bank, o_out_valid, o_out_re,
               o_out_im, o_out_last, o_busy
    );

    modport slave (
        output i_in_valid, i_in_re, i_in_im, i_done_transform,
               i_res_re, i_res_im, i_out_ready,
        input  o_in_ready, o_load_sel, o_load_wr_en, o_load_wr_addr,
               o_load_re, o_load_im, o_transform, o_res_rd_en,
               o_res_rd_addr, o_res_bank, o_out_valid, o_out_re,
               o_out_im, o_out_last, o_busy
    );

endinterface

// File: rtl/fft_io_sequencer_bit_rev.sv
// Combinational bit reversal of a log2(N)-bit address.
module bit_rev
    import fft_io_sequencer_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned AW = log2(N)
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rev
);

    // Mirror the address bits: MSB becomes LSB.
    always_comb begin
        rev = '0;
        for (int unsigned k = 0; k < AW; k++) begin
            rev[k] = addr[AW-1-k];
        end
    end

endmodule

// File: rtl/fft_io_sequencer.sv
// Top-level FFT I/O sequencer: loads N samples into RAM1 in bit-reversed
// order, kicks the transform controller, waits for done and streams the
// result bank out in natural order through a 2-entry skid FIFO.
module fft_io_sequencer
    import fft_io_sequencer_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned I = 4,
    parameter int unsigned F = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_io_sequencer_if.master   bus
);

    localparam int unsigned   AW          = log2(N);
    localparam int unsigned   W           = word_width(I, F);
    localparam logic          RESULT_BANK = result_bank(N);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(N - 1);
    localparam logic [AW:0]   RD_END      = (AW + 1)'(N);

    state_t        state;
    logic [AW-1:0] load_cnt;
    logic [AW-1:0] load_addr;
    logic [AW:0]   rd_cnt;
    logic [1:0]    occ;
    logic [1:0]    pending;
    logic          inflight;
    logic          inflight_last;
    logic [W-1:0]  fifo_re [2];
    logic [W-1:0]  fifo_im [2];
    logic [1:0]    fifo_last;
    logic          rd_ptr;
    logic          wr_ptr;
    logic          in_load;
    logic          load_hs;
    logic          out_valid;
    logic          pop;
    logic          rd_issue;

    bit_rev #(.N(N)) u_bit_rev (
        .addr (load_cnt),
        .rev  (load_addr)
    );

    // Handshakes, read issue and all combinational bus outputs.
    always_comb begin
        in_load   = (state == LOAD) && !rst;
        load_hs   = in_load && bus.i_in_valid;
        out_valid = (occ != 2'd0) && !rst;
        pop       = out_valid && bus.i_out_ready;
        // Slots still owed after this cycle's pop; counting the pop lets a
        // read overlap a drain so a ready sink gets one sample per cycle.
        pending   = occ + {1'b0, inflight} - {1'b0, pop};
        rd_issue  = (state == UNLOAD) && !rst && (rd_cnt < RD_END) && (pending < 2'd2);

        bus.o_in_ready     = in_load;
        bus.o_load_sel     = (state == LOAD);
        bus.o_load_wr_en   = load_hs;
        bus.o_load_wr_addr = load_addr;
        bus.o_load_re      = bus.i_in_re;
        bus.o_load_im      = bus.i_in_im;
        bus.o_res_rd_en    = rd_issue;
        bus.o_res_rd_addr  = rd_cnt[AW-1:0];
        bus.o_res_bank     = RESULT_BANK;
        bus.o_out_valid    = out_valid;
        bus.o_out_re       = fifo_re[rd_ptr];
        bus.o_out_im       = fifo_im[rd_ptr];
        bus.o_out_last     = out_valid && fifo_last[rd_ptr];
        bus.o_busy         = !((state == LOAD) && (load_cnt == '0));
    end

    // Sequencer FSM: load count, start pulse, done wait, read count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD;
            load_cnt        <= '0;
            rd_cnt          <= '0;
            bus.o_transform <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        if (load_cnt == LAST_ADDR) begin
                            state           <= START;
                            load_cnt        <= '0;
                            bus.o_transform <= 1'b1;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    bus.o_transform <= 1'b0;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (bus.i_done_transform) begin
                        state <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (pop && fifo_last[rd_ptr]) begin
                        state  <= LOAD;
                        rd_cnt <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Read pipeline and 2-entry output FIFO; read data lands one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ           <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (rd_cnt[AW-1:0] == LAST_ADDR);
            if (inflight) begin
                fifo_re[wr_ptr]   <= bus.i_res_re;
                fifo_im[wr_ptr]   <= bus.i_res_im;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: doc/fft_io_sequencer.md
Name: fft_io_sequencer

Overview:
- Top-level sequencer around the FFT transform controller and its ping-pong RAM banks.
- Accepts N complex samples over a valid/ready stream and writes them into RAM1 at bit-reversed addresses.
- Then pulses the transform controller's start input, waits for its done flag, and streams the N results out of the final-stage bank in natural order over a valid/ready stream.
- Owns RAM1's write port during load and the result bank's read port during unload.

Parameters:
- N, 8, transform length; power of two, at least 4.
- I, 4, integer bits per real/imag component.
- F, 4, fractional bits per component; word width W = I+F.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_in_valid  in  1  input sample valid
- o_in_ready  out  1  input sample accepted this cycle when high with i_in_valid
- i_in_re  in  W  input real component, signed fixed point
- i_in_im  in  W  input imaginary component
- o_load_sel  out  1  RAM1 write-port mux select: 1 = sequencer owns it, 0 = transform controller
- o_load_wr_en  out  1  RAM1 re/im write enable
- o_load_wr_addr  out  log2(N)  RAM1 write address (bit-reversed)
- o_load_re  out  W  RAM1 real write data
- o_load_im  out  W  RAM1 imaginary write data
- o_transform  out  1  start pulse to the transform controller
- i_done_transform  in  1  done flag from the transform controller
- o_res_rd_en  out  1  result-bank read enable
- o_res_rd_addr  out  log2(N)  result-bank read address
- o_res_bank  out  1  result bank: 0 = RAM1, 1 = RAM2; constant RESULT_BANK
- i_res_re  in  W  result-bank real read data, 1-cycle latency
- i_res_im  in  W  result-bank imaginary read data
- o_out_valid  out  1  output sample valid
- i_out_ready  in  1  downstream ready
- o_out_re  out  W  output real component
- o_out_im  out  W  output imaginary component
- o_out_last  out  1  marks sample index N-1
- o_busy  out  1  high unless in LOAD with zero samples accepted

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state LOAD; load_cnt, rd_cnt, FIFO occupancy and in-flight flag all 0. o_transform, o_res_rd_en, o_out_valid, o_out_last and o_load_wr_en are 0. o_in_ready is forced 0 while rst is high. Reset mid-operation abandons the frame immediately, with no partial output.
- RESULT_BANK = (log2(N)-1) odd ? 1 : 0. For N=8 this is RAM1; for N=16 it is RAM2.
- States: LOAD, START, WAIT, UNLOAD.
- LOAD:
  - o_in_ready = 1 and o_load_sel = 1.
  - On handshake, in the same cycle and combinationally: o_load_wr_en = 1, o_load_wr_addr = bitrev(load_cnt), data passes through.
  - load_cnt increments on each handshake.
  - The handshake with load_cnt = N-1 moves to START and clears load_cnt.
- START:
  - o_transform = 1 for exactly one cycle, then go to WAIT. The controller triggers on the falling edge of this pulse.
  - o_in_ready = 0 and o_load_sel = 0.
- WAIT: hold until i_done_transform = 1, then go to UNLOAD. i_done_transform is ignored in every other state.
- UNLOAD read side:
  - Issue a read (o_res_rd_en = 1, o_res_rd_addr = rd_cnt) when rd_cnt < N and FIFO occupancy + in-flight < 2. rd_cnt then increments.
  - Read data is pushed into a 2-entry output FIFO one cycle after the read, tagged last when its address was N-1.
- UNLOAD output side:
  - o_out_valid = FIFO non-empty. o_out_re, o_out_im and o_out_last come from the FIFO head.
  - Pop on o_out_valid & i_out_ready.
  - Popping the last entry returns to LOAD with rd_cnt = 0.
- Latency: first read is issued in the first UNLOAD cycle t; o_out_valid first rises at t+2.
- Throughput: with i_out_ready held high, one sample per cycle after the first.
- Backpressure: with i_out_ready = 0, the FIFO fills to 2 and reads stall. Data is never dropped or duplicated.
- A simultaneous push and pop keeps the occupancy unchanged.
- Outputs must not change while o_out_valid = 1 and i_out_ready = 0.
- i_in_valid outside LOAD is ignored.

Decomposition:
- Shared fft_pkg holds: the log2 function, W = I+F, the RESULT_BANK derivation, and the state encoding constants LOAD/START/WAIT/UNLOAD.
- One sub-module: bit_rev, a combinational log2(N)-bit reversal parameterised by N. It is reused by the top level for load addressing.
- The 2-entry output FIFO stays inline.

Test Plan:
- Load ramp re = 0..7, im = 0, i_in_valid always high -> o_load_wr_addr = 0,4,2,6,1,5,3,7 on consecutive cycles; o_transform high for exactly 1 cycle, on the cycle after the 8th handshake.
- Model returns i_done_transform 20 cycles later; RAM holds k*3 at address k; i_out_ready = 1 -> o_out_valid rises 2 cycles after UNLOAD entry; outputs 0,3,...,21 on consecutive cycles; o_out_last only on 21; then o_in_ready = 1.
- Unload with i_out_ready toggling 1,0,0,1,... -> all 8 values in order, no duplicates; data stable while stalled; o_res_rd_en never issues when occupancy + in-flight = 2.
- Assert rst after 5 load handshakes -> next cycle o_busy = 0; a fresh 8-sample load writes starting at address 0.
- Pulse i_done_transform during LOAD and START -> ignored; the sequencer still waits in WAIT for a real done.
- Gapped input valid (1 every 3 cycles) -> exactly 8 writes with correct bit-reversed addresses; single o_transform pulse.
